// File: rtl/vmul_pipe_if.sv
// Operand/result handshake bundle for vmul_pipe.
// master = dispatch + writeback side, slave = multiplier.
interface vmul_pipe_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int SEW_WIDTH   = 2,
  parameter int OPSEL_WIDTH = 2
);
  logic [DATA_WIDTH-1:0]  in_vec0;
  logic [DATA_WIDTH-1:0]  in_vec1;
  logic [SEW_WIDTH-1:0]   in_sew;
  logic [OPSEL_WIDTH-1:0] in_opSel;
  logic                   in_widen;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  out_vec;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;

  modport master (
    output in_vec0, in_vec1, in_sew, in_opSel, in_widen, in_valid, out_ready,
    input  in_ready, out_vec, out_valid, out_last
  );

  modport slave (
    input  in_vec0, in_vec1, in_sew, in_opSel, in_widen, in_valid, out_ready,
    output in_ready, out_vec, out_valid, out_last
  );
endinterface

// File: rtl/vmul_pipe.sv
// Packed-SIMD lane-wise multiplier (e8/e16/e32, optional e64) with a LATENCY-deep
// stall-all pipeline and a two-beat widening sequencer. Define VMUL_MUL64_EN for e64.
module vmul_pipe #(
  parameter int DATA_WIDTH  = 64,
  parameter int SEW_WIDTH   = 2,
  parameter int OPSEL_WIDTH = 2,
  parameter int LATENCY     = 4
) (
  input logic        clk,
  input logic        rst,
  vmul_pipe_if.slave bus
);

`ifdef VMUL_MUL64_EN
  localparam int NUM_SEW = 4;
  localparam bit MUL64   = 1'b1;
`else
  localparam int NUM_SEW = 3;
  localparam bit MUL64   = 1'b0;
`endif

  typedef enum logic {IDLE, SECOND} state_t;

  // One issued beat: operands plus everything the multiply stage needs to decode it.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [1:0]            sew;
    logic                  a_signed;
    logic                  b_signed;
    logic                  low;
    logic                  widen;
    logic                  half;
    logic                  illegal;
    logic                  last;
  } beat_t;

  state_t state_q, state_d;
  beat_t  in_beat, issue, hold_q, s1_q;
  logic   issue_valid, hold_load, s1_valid_q;
  logic   stall, accept, sew_hi;
  logic [DATA_WIDTH-1:0] s1_result;
  logic [DATA_WIDTH-1:0] sew_res   [4];
  logic [DATA_WIDTH-1:0] pipe_data_q [2:LATENCY];
  logic [LATENCY:2]      pipe_valid_q;
  logic [LATENCY:2]      pipe_last_q;

  assign stall         = pipe_valid_q[LATENCY] & ~bus.out_ready;
  assign bus.in_ready  = ~rst & ~stall & (state_q == IDLE);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_vec   = pipe_data_q[LATENCY];
  assign bus.out_valid = pipe_valid_q[LATENCY];
  assign bus.out_last  = pipe_last_q[LATENCY];

  assign sew_hi = |(bus.in_sew >> 2);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    in_beat          = '0;
    in_beat.a        = bus.in_vec0;
    in_beat.b        = bus.in_vec1;
    in_beat.sew      = bus.in_sew[1:0];
    in_beat.illegal  = sew_hi | ((bus.in_sew[1:0] == 2'd3) & (bus.in_widen | ~MUL64));
    in_beat.widen    = bus.in_widen & ~in_beat.illegal;
    in_beat.low      = ~bus.in_widen & (bus.in_opSel[1:0] == 2'b01);
    // Widening treats opSel 01 as signed x signed; otherwise bit 1 marks a signed A.
    in_beat.a_signed = bus.in_opSel[1] | (bus.in_widen & bus.in_opSel[0]);
    in_beat.b_signed = bus.in_opSel[0] & (bus.in_opSel[1] | bus.in_widen);
    in_beat.half     = 1'b0;
    in_beat.last     = ~in_beat.widen;
  end

  always_comb begin
    state_d     = state_q;
    issue       = in_beat;
    issue_valid = 1'b0;
    hold_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          issue_valid = 1'b1;
          if (in_beat.widen) begin
            hold_load = 1'b1;
            state_d   = SECOND;
          end
        end
      end
      SECOND: begin
        issue      = hold_q;
        issue.half = 1'b1;
        issue.last = 1'b1;
        if (!stall) begin
          issue_valid = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Products are formed from stage 1 at full 2*SEW precision and selected before stage 2.
  for (genvar k = 0; k < 4; k++) begin : g_sew
    if (k < NUM_SEW) begin : g_on
      localparam int SEW = 8 << k;
      localparam int N   = DATA_WIDTH / SEW;
      logic [2*SEW-1:0]      prod [N];
      logic [DATA_WIDTH-1:0] narrow;

      for (genvar i = 0; i < N; i++) begin : g_lane
        logic [SEW-1:0] ea, eb;
        assign ea = s1_q.a[i*SEW +: SEW];
        assign eb = s1_q.b[i*SEW +: SEW];
        assign prod[i] = {{SEW{s1_q.a_signed & ea[SEW-1]}}, ea} *
                         {{SEW{s1_q.b_signed & eb[SEW-1]}}, eb};
        assign narrow[i*SEW +: SEW] = s1_q.low ? prod[i][SEW-1:0] : prod[i][2*SEW-1:SEW];
      end

      if (k < 3) begin : g_widen
        logic [DATA_WIDTH-1:0] wide;
        for (genvar j = 0; j < N / 2; j++) begin : g_elem
          assign wide[j*2*SEW +: 2*SEW] = s1_q.half ? prod[N/2 + j] : prod[j];
        end
        assign sew_res[k] = s1_q.widen ? wide : narrow;
      end else begin : g_narrow
        assign sew_res[k] = narrow;
      end
    end else begin : g_off
      assign sew_res[k] = '0;
    end
  end

  assign s1_result = s1_q.illegal ? '0 : sew_res[s1_q.sew];

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      s1_q         <= '0;
      s1_valid_q   <= 1'b0;
      pipe_valid_q <= '0;
      pipe_last_q  <= '0;
      // NOTE: the data stages are reset too, because out_vec must read zero out of reset.
      for (int k = 2; k <= LATENCY; k++) pipe_data_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (hold_load) hold_q <= in_beat;
      if (!stall) begin
        s1_valid_q      <= issue_valid;
        s1_q            <= issue;
        pipe_valid_q[2] <= s1_valid_q;
        pipe_last_q[2]  <= s1_q.last;
        pipe_data_q[2]  <= s1_result;
        for (int k = 3; k <= LATENCY; k++) begin
          pipe_valid_q[k] <= pipe_valid_q[k-1];
          pipe_last_q[k]  <= pipe_last_q[k-1];
          pipe_data_q[k]  <= pipe_data_q[k-1];
        end
      end
    end
  end

endmodule
